// File: rtl/frogger_pkg.sv
// Shared types and constants for the frogger game controller.
package frogger_pkg;

  typedef logic [2:0] speed_t;
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_PLAY      = 3'd1;
  localparam state_t ST_HIT       = 3'd2;
  localparam state_t ST_WIN       = 3'd3;
  localparam state_t ST_GAME_OVER = 3'd4;

  localparam logic [4:0] ROW_START  = 5'd0;
  localparam logic [4:0] ROW_MEDIAN = 5'd8;
  localparam logic [4:0] ROW_GOAL   = 5'd16;
  localparam logic [3:0] SPAWN_COL  = 4'd7;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Rows where cars drive; kerb, median and goal are always safe.
  function automatic logic is_lane(input logic [4:0] row);
    return (row != ROW_START) && (row != ROW_MEDIAN) && (row < ROW_GOAL);
  endfunction

endpackage

// File: rtl/frogger_game_ctrl_pause_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module pause_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_cnt <= '0;
    else if (i_load)              r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/frogger_game_ctrl.sv
// Game sequencer: collisions, lives, level/speed, score, respawn and freeze.
// Optional post-respawn collision immunity enabled by FROGGER_GRACE_EN.
module frogger_game_ctrl
  import frogger_pkg::*;
#(
  parameter int LIVES_INIT   = 3,
  parameter int MAX_LEVEL    = 6,
  parameter int HIT_CYCLES   = 25000,
  parameter int WIN_CYCLES   = 25000,
  parameter int GRACE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  frog_row,
  input  logic [3:0]  frog_col,
  input  logic [15:0] row_bits,
  output logic [2:0]  speed,
  output logic [2:0]  lives,
  output logic [7:0]  score,
  output logic        frog_respawn,
  output logic        freeze,
  output logic        game_over
`ifdef FROGGER_GRACE_EN
  , output logic      grace
`endif
);

  localparam int CNT_W = $clog2(max3(HIT_CYCLES, WIN_CYCLES, GRACE_CYCLES) + 1);
  // Pause timer counts down to zero and exits on the zero cycle, so load N-1.
  localparam logic [CNT_W-1:0] HIT_LOAD = CNT_W'(HIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WIN_CYCLES - 1);
  localparam speed_t     MAX_SPD   = speed_t'(MAX_LEVEL);
  localparam logic [2:0] LIVES_LD  = 3'(LIVES_INIT);

  state_t     r_state;
  speed_t     r_speed;
  logic [2:0] r_lives;
  logic [7:0] r_score;
  logic       r_respawn;

  logic w_hit_raw, w_hit, w_goal, w_pause_done, w_enter_play, w_in_play;

  assign w_in_play = (r_state == ST_PLAY);
  assign w_hit_raw = w_in_play && is_lane(frog_row) && row_bits[frog_col];
  assign w_goal    = w_in_play && (frog_row == ROW_GOAL);

  assign w_enter_play = (((r_state == ST_IDLE) || (r_state == ST_GAME_OVER)) && start)
                     || ((r_state == ST_HIT) && w_pause_done && (r_lives != 3'd0))
                     || ((r_state == ST_WIN) && w_pause_done);

`ifdef FROGGER_GRACE_EN
  localparam logic [CNT_W-1:0] GRACE_LOAD = CNT_W'(GRACE_CYCLES);
  logic w_grace_done;

  pause_timer #(.W(CNT_W)) u_grace (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_enter_play),
    .i_load_val (GRACE_LOAD),
    .i_en       (w_in_play),
    .o_done     (w_grace_done)
  );

  assign w_hit = w_hit_raw && w_grace_done;
  assign grace = w_in_play && !w_grace_done;
`else
  assign w_hit = w_hit_raw;
`endif

  pause_timer #(.W(CNT_W)) u_pause (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_hit || w_goal),
    .i_load_val (w_hit ? HIT_LOAD : WIN_LOAD),
    .i_en       ((r_state == ST_HIT) || (r_state == ST_WIN)),
    .o_done     (w_pause_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_speed   <= '0;
      r_lives   <= LIVES_LD;
      r_score   <= '0;
      r_respawn <= 1'b0;
    end else begin
      r_respawn <= w_enter_play;
      case (r_state)
        ST_IDLE, ST_GAME_OVER: begin
          if (start) begin
            r_state <= ST_PLAY;
            r_lives <= LIVES_LD;
            r_speed <= '0;
            r_score <= '0;
          end
        end
        ST_PLAY: begin
          if (w_hit) begin
            r_state <= ST_HIT;
            if (r_lives != 3'd0) r_lives <= r_lives - 3'd1;
          end else if (w_goal) begin
            r_state <= ST_WIN;
            if (r_score != 8'hFF) r_score <= r_score + 8'd1;
          end
        end
        ST_HIT: begin
          if (w_pause_done) r_state <= (r_lives == 3'd0) ? ST_GAME_OVER : ST_PLAY;
        end
        ST_WIN: begin
          if (w_pause_done) begin
            r_state <= ST_PLAY;
            r_speed <= (r_speed < MAX_SPD) ? r_speed + 3'd1 : MAX_SPD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign speed        = r_speed;
  assign lives        = r_lives;
  assign score        = r_score;
  assign frog_respawn = r_respawn;
  assign freeze       = !w_in_play;
  assign game_over    = (r_state == ST_GAME_OVER);

endmodule

// File: doc/frogger_game_ctrl.md
Name: frogger_game_ctrl

Overview:
- Game-level sequencer for the traffic datapath: drives the 3-bit `speed` select into the car-lane shifter.
- Detects frog/car collisions from the occupancy row under the frog.
- Tracks lives, level and score.
- Issues respawn and freeze commands to the frog mover and the display.
- Sits between the player-input/frog-position logic and the lane generator.

Parameters:
- LIVES_INIT, 3, lives loaded at game start (1..7).
- MAX_LEVEL, 6, highest speed code; level saturates here.
- HIT_CYCLES, 25000, pause length after a collision, in clk cycles.
- WIN_CYCLES, 25000, pause length after reaching the goal row.
- GRACE_CYCLES, 50000, post-respawn collision-immune window (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse from the debounced start key
- frog_row  in  5  frog row; 0 = start kerb, 1..15 = lanes, 8 = safe median, 16 = goal
- frog_col  in  4  frog column 0..15
- row_bits  in  16  car occupancy of lane frog_row (external mux); ignored for rows 0, 8, 16
- speed  out  3  speed code to the car-lane shifter; equals current level
- lives  out  3  remaining lives
- score  out  8  levels cleared, saturating
- frog_respawn  out  1  one-cycle pulse: frog mover returns frog to row 0, column 7
- freeze  out  1  high while frog movement must be ignored
- game_over  out  1  high in GAME_OVER state

Behaviour:
- Reset (async, immediate): state=IDLE, speed=0, lives=LIVES_INIT, score=0, frog_respawn=0, freeze=1, game_over=0, all counters 0.
- hit = (state==PLAY) && frog_row in {1..7, 9..15} && row_bits[frog_col]. Combinational; acted on at the next clk edge.
- goal = (state==PLAY) && frog_row==16.
- IDLE:
  - freeze=1.
  - start -> PLAY; same edge: lives=LIVES_INIT, speed=0, score=0, frog_respawn pulses.
- PLAY:
  - freeze=0.
  - hit -> HIT; lives decrements by 1, counter cleared.
  - else goal -> WIN; score+1 (hold at 255), counter cleared.
  - hit has priority if both are true (not reachable with the row rules; still required).
- HIT:
  - freeze=1; counter runs 0..HIT_CYCLES-1.
  - At terminal count: lives==0 -> GAME_OVER; else -> PLAY with a frog_respawn pulse.
- WIN:
  - freeze=1; counter runs 0..WIN_CYCLES-1.
  - At terminal count: speed = min(speed+1, MAX_LEVEL); -> PLAY with a frog_respawn pulse.
  - At MAX_LEVEL, speed holds and score keeps incrementing.
- GAME_OVER:
  - freeze=1, game_over=1; lives=0 and score hold.
  - start -> PLAY, same as from IDLE.
- start is ignored in PLAY, HIT and WIN.
- frog_respawn is exactly 1 cycle wide, asserted on the edge entering PLAY.
- Latency from a hit/goal condition to the state change: 1 cycle.
- Wrap-around rules:
  - Lives never underflow; decrementing from 1 gives 0, then GAME_OVER.
  - Speed never exceeds MAX_LEVEL.
- Pause counter width is $clog2(max(HIT_CYCLES, WIN_CYCLES, GRACE_CYCLES)+1).
- Reset asserted mid-pause or mid-game forces IDLE immediately; no respawn pulse is emitted.

Optional Feature:
- Macro FROGGER_GRACE_EN.
- When defined:
  - On every entry to PLAY, a grace counter loads GRACE_CYCLES.
  - hit is masked while the grace counter is nonzero; the counter decrements once per cycle in PLAY.
  - goal is still honoured during grace.
  - Extra output `grace` (1 bit) is high while masked, for blinking the frog.
- When undefined:
  - No grace counter.
  - hit is effective on the first PLAY cycle.
  - `grace` port is absent.

Decomposition:
- Package frogger_pkg:
  - state enum (IDLE, PLAY, HIT, WIN, GAME_OVER)
  - ROW_START=0, ROW_MEDIAN=8, ROW_GOAL=16
  - SPAWN_COL=7
  - speed_t (logic [2:0])
- Sub-module pause_timer: loadable down-counter with a done flag; instantiated for HIT/WIN and, under the macro, for grace.

Test Plan (override HIT_CYCLES=WIN_CYCLES=4, GRACE_CYCLES=6):
- Reset then start pulse -> next cycle state PLAY, freeze=0, lives=3, speed=0, frog_respawn high exactly 1 cycle.
- frog_row=3, frog_col=5, row_bits=16'h0020 -> lives 3->2, freeze=1 for 4 cycles, then frog_respawn and PLAY. Same input with row_bits=16'h0010 -> no change.
- frog_row=8 with row_bits=16'hFFFF -> no hit. frog_row=16 -> score=1, after the pause speed=1. Repeat 8 goals -> speed saturates at 6, score=8.
- Three hits in a row -> lives=0, game_over=1; start -> lives=3, speed=0, score=0, game_over=0.
- Assert reset during a HIT pause -> immediate IDLE, speed=0, no frog_respawn pulse.
- With FROGGER_GRACE_EN: hit presented 3 cycles after respawn -> ignored, grace=1; hit at cycle 7 -> lives decrements.
